alu_seq: RTL and testbench

//  Parametrised, registered successor to the combinational i281 ALU. Accepts one operation per

---
 rtl/alu_seq.sv | 138 +++++++++++++
 tb/tb_alu_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with carry-chained ADC/SBB, CMP and an iterative shift-add multiply.
// Holds the flags register; one operation is in flight at a time.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] alu_in_one,
    input  logic [WIDTH-1:0] alu_in_two,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       alu_flags
);
    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_ADC = 3'b100;
    localparam logic [2:0] OP_SBB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               accept;

    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;

    // Single-cycle datapath, evaluated on the live inputs so it is captured at the accept edge.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH-1:0] res;
    logic             c_f;
    logic             v_f;
    logic [3:0]       flags_next;

    always_comb begin
        sum     = '0;
        cin_ext = '0;
        res     = '0;
        c_f     = 1'b0;
        v_f     = 1'b0;
        case (op)
            OP_SHL: begin
                res = {alu_in_one[WIDTH-2:0], 1'b0};
                c_f = alu_in_one[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, alu_in_one[WIDTH-1:1]};
                c_f = alu_in_one[0];
            end
            OP_ADD, OP_ADC: begin
                cin_ext = {{WIDTH{1'b0}}, (op == OP_ADC) ? alu_flags[3] : 1'b0};
                sum     = {1'b0, alu_in_one} + {1'b0, alu_in_two} + cin_ext;
                res     = sum[WIDTH-1:0];
                c_f     = sum[WIDTH];
                v_f     = (alu_in_one[WIDTH-1] == alu_in_two[WIDTH-1]) &
                          (res[WIDTH-1] != alu_in_one[WIDTH-1]);
            end
            default: begin
                // SUB, SBB and CMP; MUL goes through the iterative path instead.
                cin_ext = {{WIDTH{1'b0}}, (op == OP_SBB) ? alu_flags[3] : 1'b1};
                sum     = {1'b0, alu_in_one} + {1'b0, ~alu_in_two} + cin_ext;
                res     = sum[WIDTH-1:0];
                c_f     = sum[WIDTH];
                v_f     = (alu_in_one[WIDTH-1] != alu_in_two[WIDTH-1]) &
                          (res[WIDTH-1] != alu_in_one[WIDTH-1]);
            end
        endcase
        flags_next = {c_f, v_f, res[WIDTH-1], (res == '0)};
    end

    // One shift-add step: add multiplicand into the upper half when the current LSB is set.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_hi;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        mul_hi   = |acc_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            alu_result <= '0;
            alu_flags  <= '0;
            count      <= '0;
            acc        <= '0;
            mcand      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                            count <= '0;
                            acc   <= {{WIDTH{1'b0}}, alu_in_two};
                            mcand <= alu_in_one;
                        end else begin
                            state     <= S_DONE;
                            alu_flags <= flags_next;
                            if (op != OP_CMP) alu_result <= res;
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state      <= S_DONE;
                        count      <= '0;
                        alu_result <= acc_next[WIDTH-1:0];
                        alu_flags  <= {mul_hi, mul_hi, acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0)};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): vector table plus scoreboard, with hand-written multi-cycle sequences.
module tb_alu_seq;
    localparam int W = 8;
    localparam logic [2:0] SHL = 3'd0, SHR = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] ADC = 3'd4, SBB = 3'd5, MUL = 3'd6, CMP = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] alu_in_one = '0;
    logic [W-1:0] alu_in_two = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags;

    alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .alu_in_one(alu_in_one), .alu_in_two(alu_in_two), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] sb[$];
    logic [7:0]  m_result = '0;
    logic [3:0]  m_flags  = '0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every completed output handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %0h expected none", alu_result);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                check("result", {24'd0, alu_result}, {24'd0, e[11:4]});
                check("flags", {28'd0, alu_flags}, {28'd0, e[3:0]});
            end
        end
    end

    function automatic logic [11:0] model(input logic [2:0] o, input int a, input int b);
        int s, sa, sbv, sr, cin;
        logic [7:0] r;
        logic c, v;
        cin = int'(m_flags[3]);
        sa  = (a > 127) ? a - 256 : a;
        sbv = (b > 127) ? b - 256 : b;
        s = 0; sr = 0; c = 1'b0; v = 1'b0;
        case (o)
            SHL: begin r = 8'(a * 2); c = (a >= 128); end
            SHR: begin r = 8'(a / 2); c = ((a % 2) == 1); end
            ADD, ADC: begin
                s = a + b + ((o == ADC) ? cin : 0);
                sr = sa + sbv + ((o == ADC) ? cin : 0);
                r = 8'(s); c = (s > 255); v = (sr > 127) || (sr < -128);
            end
            SUB, CMP: begin
                s = a - b; sr = sa - sbv;
                r = 8'(s); c = (a >= b); v = (sr > 127) || (sr < -128);
            end
            SBB: begin
                s = a + (255 - b) + cin; sr = sa - sbv - 1 + cin;
                r = 8'(s); c = (s > 255); v = (sr > 127) || (sr < -128);
            end
            default: begin
                s = a * b; r = 8'(s); c = ((s / 256) != 0); v = c;
            end
        endcase
        return {((o == CMP) ? m_result : r), c, v, r[7], (r == 8'd0)};
    endfunction

    // Drives one request, waits (bounded) for acceptance, pushes its expectation at the accept edge.
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [11:0] exp, input bit rnd, output int stalls);
        stalls = 0;
        in_valid = 1'b1; op = o; alu_in_one = a; alu_in_two = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: got no in_ready expected within 100 cycles");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 1) == 1);
        end
        sb.push_back(exp);
        m_result = exp[11:4];
        m_flags  = exp[3:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int st, k, first, cnt;
        tbl[0]  = '{ADD, 8'h7F, 8'h01, 8'h80, 4'b0110};
        tbl[1]  = '{SUB, 8'h05, 8'h05, 8'h00, 4'b1001};
        tbl[2]  = '{ADC, 8'h01, 8'h01, 8'h03, 4'b0000};
        tbl[3]  = '{SBB, 8'h00, 8'h01, 8'hFE, 4'b0010};
        tbl[4]  = '{MUL, 8'h10, 8'h10, 8'h00, 4'b1101};
        tbl[5]  = '{MUL, 8'h0F, 8'h03, 8'h2D, 4'b0000};
        tbl[6]  = '{SHL, 8'h81, 8'h00, 8'h02, 4'b1000};
        tbl[7]  = '{SHR, 8'h81, 8'h00, 8'h40, 4'b1000};
        tbl[8]  = '{ADD, 8'hFF, 8'h01, 8'h00, 4'b1001};
        tbl[9]  = '{ADD, 8'h01, 8'h02, 8'h03, 4'b0000};
        tbl[10] = '{CMP, 8'h03, 8'h05, 8'h03, 4'b0010};
        tbl[11] = '{ADC, 8'h80, 8'h80, 8'h00, 4'b1101};
        tbl[12] = '{SBB, 8'h80, 8'h01, 8'h7F, 4'b1100};
        tbl[13] = '{MUL, 8'hFF, 8'hFF, 8'h01, 4'b1100};

        // Reset held with a pending request
        rst_n = 1'b0; in_valid = 1'b1; op = ADD; alu_in_one = 8'h11; alu_in_two = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, alu_result}, 32'h00);
        check("rst_flags", {28'd0, alu_flags}, 32'h0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Vector table, back-to-back with out_ready=1
        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].r, tbl[i].f}, 1'b0, st);
        end
        repeat (12) @(posedge clk);
        #1;

        // Single-cycle ops sustain one per cycle
        for (int i = 0; i < 4; i++) begin
            do_op(ADD, 8'(i), 8'h10, model(ADD, i, 16), 1'b0, st);
            if (i > 0) check("throughput_stall", st, 0);
        end
        repeat (3) @(posedge clk);
        #1;

        // MUL latency
        in_valid = 1'b1; op = MUL; alu_in_one = 8'h10; alu_in_two = 8'h10;
        @(negedge clk);
        check("mul_accept", {31'd0, in_ready}, 32'd1);
        sb.push_back(model(MUL, 16, 16));
        m_result = 8'h00; m_flags = 4'b1101;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 0; first = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!in_ready) cnt++;
            if (out_valid) begin first = k; break; end
        end
        check("mul_busy_cycles", cnt, 8);
        check("mul_latency", first, 9);
        @(posedge clk);
        #1;

        // Backpressure: result held, single handshake on release
        out_ready = 1'b0;
        do_op(ADD, 8'h01, 8'h02, model(ADD, 1, 2), 1'b0, st);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", {24'd0, alu_result}, 32'h03);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_single_handshake", {31'd0, out_valid}, 32'd0);
        check("bp_drained", sb.size(), 0);

        // Reset during the 4th multiply iteration
        @(posedge clk);
        #1;
        in_valid = 1'b1; op = MUL; alu_in_one = 8'h0F; alu_in_two = 8'h03;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_result = 8'h00; m_flags = 4'b0000;
        @(negedge clk);
        check("midmul_idle", {31'd0, in_ready}, 32'd1);
        check("midmul_flags", {28'd0, alu_flags}, 32'h0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midmul_no_output", cnt, 0);
        @(posedge clk);
        #1;
        do_op(ADD, 8'h01, 8'h02, {8'h03, 4'b0000}, 1'b0, st);
        do_op(CMP, 8'h03, 8'h05, {8'h03, 4'b0010}, 1'b0, st);

        // Random ops under random backpressure, expectations from the model
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            logic [7:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            do_op(o, a, b, model(o, int'(a), int'(b)), 1'b1, st);
            out_ready = ($urandom_range(0, 1) == 1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("final_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
